// File: rtl/pipe_hazard_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | pipe_hazard_unit: stall/flush/forward control with PC-write tracking and  |
// | saturating stall/flush event counters.                                    |
// | Revision: 1.0                                                             |
// +--------------------------------------------------------------------------+
module pipe_hazard_unit #(
  parameter int REG_BITS = 4,
  parameter int CNT_W    = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_BITS-1:0] RA1D,
  input  logic [REG_BITS-1:0] RA2D,
  input  logic [REG_BITS-1:0] RA1E,
  input  logic [REG_BITS-1:0] RA2E,
  input  logic [REG_BITS-1:0] WA3E,
  input  logic [REG_BITS-1:0] WA3M,
  input  logic [REG_BITS-1:0] WA3W,
  input  logic                RegWriteE,
  input  logic                RegWriteM,
  input  logic                RegWriteW,
  input  logic                MemtoRegE,
  input  logic                PCSrcD,
  input  logic                BranchTakenE,
  input  logic                MemReadyM,
  output logic [1:0]          ForwardAE,
  output logic [1:0]          ForwardBE,
  output logic                StallF,
  output logic                StallD,
  output logic                StallE,
  output logic                StallM,
  output logic                FlushD,
  output logic                FlushE,
  output logic [CNT_W-1:0]    StallCount,
  output logic [CNT_W-1:0]    FlushCount
);

  localparam logic [REG_BITS-1:0] c_pc_reg  = REG_BITS'(15);
  localparam logic [CNT_W-1:0]    c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  logic                r_pend_e;
  logic                r_pend_m;
  logic                r_pend_w;
  logic [CNT_W-1:0]    r_stall_cnt;
  logic [CNT_W-1:0]    r_flush_cnt;

  logic                w_memstall;
  logic                w_ldraw;
  logic                w_ldrstall;
  logic                w_pcwr_pending;
  logic                w_stall_f;
  logic                w_stall_d;
  logic                w_stall_e;
  logic                w_stall_m;
  logic                w_flush_d;
  logic                w_flush_e;
  logic [REG_BITS-1:0] w_ra_e [2];
  logic [1:0]          w_fwd  [2];

  assign w_ra_e[0] = RA1E;
  assign w_ra_e[1] = RA2E;

  // Memory stage has priority over Writeback; R15 reads always come from the PC path.
  for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
    always_comb begin
      w_fwd[gi] = 2'b00;
      if (w_ra_e[gi] != c_pc_reg) begin
        if (RegWriteM && (WA3M == w_ra_e[gi])) begin
          w_fwd[gi] = 2'b10;
        end else if (RegWriteW && (WA3W == w_ra_e[gi])) begin
          w_fwd[gi] = 2'b01;
        end
      end
    end
  end

  assign w_memstall     = ~MemReadyM;
  assign w_ldraw        = MemtoRegE & RegWriteE & ((WA3E == RA1D) | (WA3E == RA2D));
  assign w_ldrstall     = w_ldraw & ~BranchTakenE;
  assign w_pcwr_pending = PCSrcD | r_pend_e | r_pend_m;

  always_comb begin
    w_stall_f = 1'b1;
    w_stall_d = 1'b1;
    w_stall_e = 1'b1;
    w_stall_m = 1'b1;
    w_flush_d = 1'b0;
    w_flush_e = 1'b0;
    if (!w_memstall) begin
      w_stall_f = w_ldrstall | w_pcwr_pending;
      w_stall_d = w_ldrstall;
      w_stall_e = 1'b0;
      w_stall_m = 1'b0;
      w_flush_d = w_pcwr_pending | r_pend_w | BranchTakenE;
      w_flush_e = w_ldrstall | BranchTakenE;
    end
  end

  // PC-write shift state freezes along with the rest of the pipeline.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pend_e <= 1'b0;
      r_pend_m <= 1'b0;
      r_pend_w <= 1'b0;
    end else if (!w_memstall) begin
      r_pend_e <= PCSrcD & ~w_flush_e;
      r_pend_m <= r_pend_e;
      r_pend_w <= r_pend_m;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
    end else if (w_stall_d && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + c_cnt_one;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_flush_cnt <= '0;
    end else if (w_flush_e && (r_flush_cnt != {CNT_W{1'b1}})) begin
      r_flush_cnt <= r_flush_cnt + c_cnt_one;
    end
  end

  // All controls are forced quiet while reset is held.
  assign ForwardAE  = rst ? w_fwd[0] : 2'b00;
  assign ForwardBE  = rst ? w_fwd[1] : 2'b00;
  assign StallF     = rst & w_stall_f;
  assign StallD     = rst & w_stall_d;
  assign StallE     = rst & w_stall_e;
  assign StallM     = rst & w_stall_m;
  assign FlushD     = rst & w_flush_d;
  assign FlushE     = rst & w_flush_e;
  assign StallCount = rst ? r_stall_cnt : '0;
  assign FlushCount = rst ? r_flush_cnt : '0;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_pipe_hazard_unit: directed scenarios plus randomized run against a     |
// | behavioural model of the hazard rules. Revision: 1.0                      |
// +--------------------------------------------------------------------------+
module tb_pipe_hazard_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
  logic       RegWriteE, RegWriteM, RegWriteW, MemtoRegE;
  logic       PCSrcD, BranchTakenE, MemReadyM;

  logic [1:0]  fa, fb, fa4, fb4;
  logic        sf, sd, se, sm, fd, fe;
  logic        sf4, sd4, se4, sm4, fd4, fe4;
  logic [15:0] scnt, fcnt;
  logic [3:0]  scnt4, fcnt4;
  wire  [9:0]  obs = {fa, fb, sf, sd, se, sm, fd, fe};

  int errors = 0;
  int checks = 0;

  // Model state: ages of in-flight PC writes (1=E, 2=M, 3=W) and event counts.
  int ages[$];
  int stall_cnt, flush_cnt, stall_cnt4, flush_cnt4;

  always #5 clk = ~clk;

  pipe_hazard_unit #(.REG_BITS(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .PCSrcD(PCSrcD), .BranchTakenE(BranchTakenE),
    .MemReadyM(MemReadyM),
    .ForwardAE(fa), .ForwardBE(fb),
    .StallF(sf), .StallD(sd), .StallE(se), .StallM(sm),
    .FlushD(fd), .FlushE(fe),
    .StallCount(scnt), .FlushCount(fcnt)
  );

  pipe_hazard_unit #(.REG_BITS(4), .CNT_W(4)) dut4 (
    .clk(clk), .rst(rst),
    .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
    .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .PCSrcD(PCSrcD), .BranchTakenE(BranchTakenE),
    .MemReadyM(MemReadyM),
    .ForwardAE(fa4), .ForwardBE(fb4),
    .StallF(sf4), .StallD(sd4), .StallE(se4), .StallM(sm4),
    .FlushD(fd4), .FlushE(fe4),
    .StallCount(scnt4), .FlushCount(fcnt4)
  );

  function automatic logic [1:0] m_fwd(input logic [3:0] ra);
    if (ra == 4'd15) return 2'b00;
    if (RegWriteM && WA3M == ra) return 2'b10;
    if (RegWriteW && WA3W == ra) return 2'b01;
    return 2'b00;
  endfunction

  // Expected {ForwardAE, ForwardBE, StallF, StallD, StallE, StallM, FlushD, FlushE}.
  function automatic logic [9:0] model_comb();
    logic ldr, pcwr, pw;
    logic [1:0] xa, xb;
    if (!rst) return 10'b0;
    ldr  = MemtoRegE && RegWriteE && (WA3E == RA1D || WA3E == RA2D) && !BranchTakenE;
    pcwr = PCSrcD;
    pw   = 1'b0;
    foreach (ages[i]) begin
      if (ages[i] < 3) pcwr = 1'b1;
      else pw = 1'b1;
    end
    xa = m_fwd(RA1E);
    xb = m_fwd(RA2E);
    if (!MemReadyM) return {xa, xb, 6'b111100};
    return {xa, xb, ldr | pcwr, ldr, 2'b00, pcwr | pw | BranchTakenE, ldr | BranchTakenE};
  endfunction

  function automatic int sat(input int v, input int maxv);
    return (v < maxv) ? v + 1 : maxv;
  endfunction

  task automatic model_edge();
    logic [9:0] e;
    int nq[$];
    e = model_comb();
    if (!rst) begin
      ages.delete();
      stall_cnt = 0; flush_cnt = 0; stall_cnt4 = 0; flush_cnt4 = 0;
      return;
    end
    if (e[4]) begin stall_cnt = sat(stall_cnt, 65535); stall_cnt4 = sat(stall_cnt4, 15); end
    if (e[0]) begin flush_cnt = sat(flush_cnt, 65535); flush_cnt4 = sat(flush_cnt4, 15); end
    if (MemReadyM) begin
      foreach (ages[i]) if (ages[i] < 3) nq.push_back(ages[i] + 1);
      if (PCSrcD && !e[0]) nq.push_back(1);
      ages = nq;
    end
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, PCSrcD, BranchTakenE} = '0;
    MemReadyM = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #1;
    tick();
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1'b0;
    RegWriteM = 1'b1; WA3M = 4'd3; RA1E = 4'd3; PCSrcD = 1'b1; MemReadyM = 1'b0;
    #1;
    tick();
    checks++;
    if (obs !== 10'b0 || scnt !== 16'd0 || fcnt !== 16'd0) begin
      errors++;
      $display("FAIL reset: outputs=%b stall=%0d flush=%0d expected all zero", obs, scnt, fcnt);
    end
    clear_inputs();
    rst = 1'b1;
    #1;
    checks++;
    if (obs !== 10'b0) begin
      errors++;
      $display("FAIL reset_release: outputs=%b expected 0", obs);
    end
  endtask

  task automatic test_forwarding();
    clear_inputs();
    RegWriteM = 1'b1; WA3M = 4'd3; RegWriteW = 1'b1; WA3W = 4'd3;
    RA1E = 4'd3; RA2E = 4'd15;
    #1;
    checks++;
    if ({fa, fb} !== 4'b1000) begin
      errors++;
      $display("FAIL fwd_mem: A=%b B=%b expected A=10 B=00", fa, fb);
    end
    RegWriteM = 1'b0;
    #1;
    checks++;
    if ({fa, fb} !== 4'b0100) begin
      errors++;
      $display("FAIL fwd_wb: A=%b B=%b expected A=01 B=00", fa, fb);
    end
    RegWriteM = 1'b1; WA3M = 4'd7; WA3W = 4'd2; RA1E = 4'd2; RA2E = 4'd7;
    #1;
    checks++;
    if ({fa, fb} !== 4'b0110) begin
      errors++;
      $display("FAIL fwd_mixed: A=%b B=%b expected A=01 B=10", fa, fb);
    end
    tick();
  endtask

  task automatic test_load_use();
    do_reset();
    clear_inputs();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5; RA2D = 4'd5; RA1D = 4'd1;
    #1;
    checks++;
    if (obs[5:0] !== 6'b110001) begin
      errors++;
      $display("FAIL load_use: stall/flush=%b expected 110001", obs[5:0]);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (scnt !== 16'd1 || fcnt !== 16'd1 || obs[5:0] !== 6'b0) begin
      errors++;
      $display("FAIL load_use_cnt: stall=%0d flush=%0d ctl=%b expected 1 1 000000", scnt, fcnt, obs[5:0]);
    end
  endtask

  task automatic test_pc_write();
    logic [5:0] exp;
    do_reset();
    clear_inputs();
    PCSrcD = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      exp = {(c < 3), 3'b000, (c < 4), 1'b0};
      checks++;
      if (obs[5:0] !== exp) begin
        errors++;
        $display("FAIL pc_write c%0d: ctl=%b expected %b", c, obs[5:0], exp);
      end
      tick();
      PCSrcD = 1'b0;
    end
  endtask

  task automatic test_branch_load();
    do_reset();
    clear_inputs();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd5; RA1D = 4'd5; BranchTakenE = 1'b1;
    #1;
    checks++;
    if (obs[5:0] !== 6'b000011) begin
      errors++;
      $display("FAIL branch_load: ctl=%b expected 000011", obs[5:0]);
    end
    tick();
    clear_inputs();
    #1;
    checks++;
    if (scnt !== 16'd0 || fcnt !== 16'd1) begin
      errors++;
      $display("FAIL branch_load_cnt: stall=%0d flush=%0d expected 0 1", scnt, fcnt);
    end
  endtask

  task automatic test_mem_freeze();
    logic [5:0] exp_tab [8];
    exp_tab = '{6'b100010, 6'b111100, 6'b111100, 6'b111100,
                6'b100010, 6'b100010, 6'b000010, 6'b000000};
    do_reset();
    clear_inputs();
    for (int c = 0; c < 8; c++) begin
      PCSrcD    = (c == 0);
      MemReadyM = !(c >= 1 && c <= 3);
      #1;
      checks++;
      if (obs[5:0] !== exp_tab[c]) begin
        errors++;
        $display("FAIL mem_freeze c%0d: ctl=%b expected %b", c, obs[5:0], exp_tab[c]);
      end
      tick();
    end
    checks++;
    if (scnt !== 16'd3 || fcnt !== 16'd0) begin
      errors++;
      $display("FAIL mem_freeze_cnt: stall=%0d flush=%0d expected 3 0", scnt, fcnt);
    end
  endtask

  task automatic test_saturation_async_reset();
    do_reset();
    clear_inputs();
    MemtoRegE = 1'b1; RegWriteE = 1'b1; WA3E = 4'd9; RA1D = 4'd9;
    for (int c = 0; c < 20; c++) tick();
    checks++;
    if (scnt4 !== 4'd15 || fcnt4 !== 4'd15 || scnt !== 16'd20) begin
      errors++;
      $display("FAIL saturation: cnt4 stall=%0d flush=%0d cnt16 stall=%0d expected 15 15 20", scnt4, fcnt4, scnt);
    end
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (obs !== 10'b0 || scnt !== 16'd0 || fcnt !== 16'd0 || scnt4 !== 4'd0 || fcnt4 !== 4'd0) begin
      errors++;
      $display("FAIL async_reset: ctl=%b s=%0d f=%0d s4=%0d f4=%0d expected all zero", obs, scnt, fcnt, scnt4, fcnt4);
    end
    tick();
    rst = 1'b1;
    clear_inputs();
    #1;
  endtask

  function automatic logic [3:0] rnd_reg();
    return ($urandom_range(0, 7) == 0) ? 4'd15 : 4'($urandom_range(0, 7));
  endfunction

  task automatic test_random();
    logic [9:0] exp;
    do_reset();
    for (int c = 0; c < 400; c++) begin
      RA1D = rnd_reg(); RA2D = rnd_reg(); RA1E = rnd_reg(); RA2E = rnd_reg();
      WA3E = rnd_reg(); WA3M = rnd_reg(); WA3W = rnd_reg();
      RegWriteE    = 1'($urandom_range(0, 1));
      RegWriteM    = 1'($urandom_range(0, 1));
      RegWriteW    = 1'($urandom_range(0, 1));
      MemtoRegE    = 1'($urandom_range(0, 1));
      PCSrcD       = ($urandom_range(0, 5) == 0);
      BranchTakenE = ($urandom_range(0, 7) == 0);
      MemReadyM    = ($urandom_range(0, 3) != 0);
      rst          = ($urandom_range(0, 59) != 0);
      #1;
      exp = model_comb();
      checks++;
      if (obs !== exp || {fa4, fb4, sf4, sd4, se4, sm4, fd4, fe4} !== exp) begin
        errors++;
        $display("FAIL rand_ctl c%0d: ctl=%b ctl4=%b expected %b", c, obs,
                 {fa4, fb4, sf4, sd4, se4, sm4, fd4, fe4}, exp);
      end
      tick();
      checks++;
      if (scnt !== 16'(stall_cnt) || fcnt !== 16'(flush_cnt) ||
          scnt4 !== 4'(stall_cnt4) || fcnt4 !== 4'(flush_cnt4)) begin
        errors++;
        $display("FAIL rand_cnt c%0d: s=%0d f=%0d s4=%0d f4=%0d expected %0d %0d %0d %0d", c,
                 scnt, fcnt, scnt4, fcnt4, stall_cnt, flush_cnt, stall_cnt4, flush_cnt4);
      end
    end
    rst = 1'b1;
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    stall_cnt = 0; flush_cnt = 0; stall_cnt4 = 0; flush_cnt4 = 0;
    #2;
    test_reset();
    test_forwarding();
    test_load_use();
    test_pc_write();
    test_branch_load();
    test_mem_freeze();
    test_saturation_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_unit.md
# pipe_hazard_unit

Pipeline hazard controller that drives the stall, flush and forwarding controls consumed by the pipeline registers, including the Decode-to-Execute control register's `flush` input. It detects load-use hazards and resolves RAW hazards by forwarding. It tracks in-flight PC writes in its own pending-shift state, handles taken branches resolved in Execute, and freezes the pipeline while data memory is not ready. Saturating stall and flush event counters are provided for performance debug.

## Interface
- `REG_BITS`, 4, register-address width (16 architectural registers, R15 = PC)
- `CNT_W`, 16, width of each event counter
- `clk` in 1: rising-edge clock
- `rst` in 1: asynchronous, active-low reset
- `RA1D`, `RA2D` in REG_BITS: source registers of the instruction in Decode
- `RA1E`, `RA2E` in REG_BITS: source registers of the instruction in Execute
- `WA3E`, `WA3M`, `WA3W` in REG_BITS: destination registers in Execute, Memory and Writeback
- `RegWriteE`, `RegWriteM`, `RegWriteW` in 1: register-write enables per stage
- `MemtoRegE` in 1: the Execute instruction is a load
- `PCSrcD` in 1: the Decode instruction writes the PC (R15 destination)
- `BranchTakenE` in 1: a branch resolved taken in Execute this cycle
- `MemReadyM` in 1: data memory ready; 0 freezes the pipeline
- `ForwardAE`, `ForwardBE` out 2: 00 = register file, 01 = Writeback result, 10 = Memory ALU result
- `StallF`, `StallD`, `StallE`, `StallM` out 1: hold the stage register
- `FlushD`, `FlushE` out 1: clear the D and E stage registers to bubbles
- `StallCount`, `FlushCount` out CNT_W: saturating event counters

## Operation
- **Forwarding** (combinational, evaluated per operand X ∈ {1,2} → A/B):
  - 10 if `RegWriteM` and `WA3M == RAXE`.
  - Otherwise 01 if `RegWriteW` and `WA3W == RAXE`.
  - Otherwise 00.
  - Never forward when `RAXE == 15`.
- **Memory stall:** `memstall = !MemReadyM`.
- **Load-use hazard:**
  - `ldraw = MemtoRegE & RegWriteE & (WA3E == RA1D | WA3E == RA2D)`.
  - `ldrstall = ldraw & !BranchTakenE`. The Decode instruction is wrong-path on a taken branch.
- **PC-write tracking:**
  - State is three flops: `pendE`, `pendM`, `pendW`.
  - `PCWrPending = PCSrcD | pendE | pendM`.
- **Outputs when `memstall` = 1:**
  - `StallF` = `StallD` = `StallE` = `StallM` = 1.
  - `FlushD` = `FlushE` = 0.
  - Pending flops hold.
- **Outputs when `memstall` = 0:**
  - `StallF = ldrstall | PCWrPending`
  - `StallD = ldrstall`
  - `StallE = StallM = 0`
  - `FlushD = PCWrPending | pendW | BranchTakenE`
  - `FlushE = ldrstall | BranchTakenE`
- **Pending update** (rising edge, only when `memstall` = 0):
  - `pendE <= PCSrcD & !FlushE`
  - `pendM <= pendE`
  - `pendW <= pendM`
- **Counters:**
  - `StallCount` increments on every edge where `StallD` = 1.
  - `FlushCount` increments on every edge where `FlushE` = 1.
  - Both saturate at all-ones with no wrap.
  - Both count during `memstall`. `FlushCount` is unaffected by `memstall` because `FlushE` = 0 then.
- **While `rst` = 0:**
  - Pending flops and counters are cleared.
  - All outputs are forced: Forward = 00, all Stall = 0, all Flush = 0, counters = 0.

## Timing
- Forward, Stall and Flush are combinational from inputs and state. They are valid in the same cycle and used by the registers at the next edge.
- Pending flops and counters update at the rising edge. Counter outputs lag the event by one cycle.
- Reset is asynchronous on assertion. The first update occurs at the first rising edge after `rst` returns to 1.
- A PC-writing instruction keeps `StallF`/`FlushD` asserted for 3 cycles (D, E, M), then `FlushD` only for 1 cycle (W): 4 cycles total without memstall.
- Simultaneous `BranchTakenE` and a load-use match:
  - `FlushE` = 1, `FlushD` = 1, `StallD` = 0.
  - `StallCount` does not increment.
- `memstall` mid-sequence freezes pending state. The sequence resumes unchanged when `MemReadyM` returns to 1.
- Reset asserted mid-sequence discards pending PC writes immediately.

## Test plan
- Forwarding: `RegWriteM`=1, `WA3M`=3, `RegWriteW`=1, `WA3W`=3, `RA1E`=3, `RA2E`=15 → `ForwardAE`=10, `ForwardBE`=00. Then drop `RegWriteM` → `ForwardAE`=01.
- Load-use: `MemtoRegE`=1, `RegWriteE`=1, `WA3E`=5, `RA2D`=5 → `StallF`=`StallD`=`FlushE`=1 for one cycle. `StallCount` reads 1 on the next cycle.
- PC write: pulse `PCSrcD`=1 for one cycle → `StallF`=1 for cycles 0–2 and `FlushD`=1 for cycles 0–3. All return to 0 at cycle 4.
- Branch with load hazard: `BranchTakenE`=1 together with a load-use match → `FlushD`=`FlushE`=1, `StallD`=0. `FlushCount` +1, `StallCount` unchanged.
- Memory freeze: `PCSrcD` pulse, then `MemReadyM`=0 for 3 cycles at cycle 1 → all Stall = 1, Flush = 0 during the freeze. The PC sequence completes 3 cycles late.
- Saturation and reset: with `CNT_W`=4, hold a load-use match for 20 cycles → `StallCount`=15. Assert `rst`=0 asynchronously → counters = 0 and all outputs = 0 immediately.
